// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO between the uart_rx bit engine and the
// UART register interface. Pushes on the rising edge of in_valid and pops on
// rd_pop. It keeps sticky overflow/break flags and drives a clock request.
// Optional level interrupt: define UART_RX_FIFO_IRQ_EN to enable irq/irq_thresh.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  output logic             g_clk_req,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_break,
  input  logic             rd_pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             brk,
  input  logic             clr_flags,
  input  logic             flush,
  input  logic [CW-1:0]    irq_thresh,
  output logic             irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_valid_q, in_valid_d;
  logic             overflow_q, overflow_d;
  logic             brk_q, brk_d;
  logic             push, pop, full, wr_en, ovf_set;

  // Push/pop qualification, pointer/count next state and sticky flags.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    push       = in_valid & ~in_valid_q;
    pop        = rd_pop & (count_q != '0);
    // A full FIFO still accepts the byte when a pop frees a slot in the same cycle.
    wr_en      = push & (~full | pop) & ~flush;
    ovf_set    = push & full & ~pop & ~flush;
    in_valid_d = in_valid;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
    overflow_d = (overflow_q & ~clr_flags) | ovf_set;
    brk_d      = (brk_q & ~clr_flags) | in_break;
  end

  // Control state registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_valid_q <= in_valid_d;
      overflow_q <= overflow_d;
      brk_q      <= brk_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge g_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign brk       = brk_q;
  assign g_clk_req = in_valid | rd_valid | flush;

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  // Level interrupt evaluated on the post-edge occupancy.
  always_comb begin
    irq_d = (count_d >= irq_thresh) && (irq_thresh != '0);
  end

  // Interrupt register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_thresh;
  assign unused_irq_thresh = ^irq_thresh;
  assign irq = 1'b0;
`endif

endmodule
